nested_interface_pipe: RTL and testbench

- Top module instantiating an outer interface that holds N_CH lanes. Each lane is a nested interface instance.
- Each lane captures input data, optionally inverts it per lane, and carries it through a DEPTH-stage valid/ready pipeline.
- All lanes advance in lockstep under one handshake. A transfer counter tracks completed output beats.
- Generalises the single-bit registered-inversion nested-interface pattern to multi-bit, multi-lane, flow-controlled operation.

---
 rtl/nested_interface_pipe.sv | 183 ++++++++++++++++++
 tb/tb_nested_interface_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nested_interface_pipe.sv
// -----------------------------------------------------------------------------
// nested_interface_pipe
//
// Purpose:
//   A multi-lane valid/ready pipeline. An outer interface (nip_bank_if) holds
//   N_CH nested lane interfaces (nip_lane_if). Each lane interface applies an
//   optional per-lane inversion to the captured input word. The processed word
//   then moves through a DEPTH-stage pipeline. All lanes share one handshake.
//   A wrapping counter tracks completed output transfers.
//
// Parameters:
//   WIDTH  data bits per lane (>=1)
//   N_CH   number of lanes (>=1)
//   DEPTH  pipeline stages from accept to output (>=1)
//   CNT_W  width of the transfer counter
//
// Ports:
//   i_clk     clock, all state changes on the rising edge
//   i_rst     asynchronous active-high reset
//   i_valid   upstream beat valid
//   o_ready   a beat can be accepted this cycle (combinational from i_ready)
//   i_data    lane k in bits [k*WIDTH +: WIDTH]
//   i_inv     per-lane invert select, sampled with the beat
//   o_valid   output beat valid
//   i_ready   downstream accepts the output beat
//   o_data    processed lanes, same packing as i_data
//   o_count   number of completed output handshakes (wraps)
//   o_parity  (only with NESTED_INTERFACE_PIPE_PARITY_EN) per-lane XOR of o_data
//
// Optional feature macro: NESTED_INTERFACE_PIPE_PARITY_EN
// -----------------------------------------------------------------------------

// One lane: combinational inversion of the captured word.
interface nip_lane_if #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  logic             inv,
  output logic [WIDTH-1:0] dout
);
  assign dout = inv ? ~din : din;
endinterface

// Outer interface: one nested lane interface per channel.
interface nip_bank_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 2
) (
  input  logic [N_CH*WIDTH-1:0] data_in,
  input  logic [N_CH-1:0]       inv_in,
  output logic [N_CH*WIDTH-1:0] data_out
);
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    nip_lane_if #(.WIDTH(WIDTH)) lane (
      .din  (data_in[gi*WIDTH +: WIDTH]),
      .inv  (inv_in[gi]),
      .dout (data_out[gi*WIDTH +: WIDTH])
    );
  end
endinterface

module nested_interface_pipe #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N_CH*WIDTH-1:0] i_data,
  input  logic [N_CH-1:0]       i_inv,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N_CH*WIDTH-1:0] o_data,
`ifdef NESTED_INTERFACE_PIPE_PARITY_EN
  output logic [N_CH-1:0]       o_parity,
`endif
  output logic [CNT_W-1:0]      o_count
);

  localparam int DW = N_CH * WIDTH;

  // Capture path: inversion happens inside the nested lane interfaces.
  logic [DW-1:0] cap_data;

  nip_bank_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bank (
    .data_in  (i_data),
    .inv_in   (i_inv),
    .data_out (cap_data)
  );

  logic [DEPTH-1:0] v_q;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] load;
  logic             xfer;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign o_valid = v_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];
  assign o_ready = load[0];
  assign xfer    = o_valid & i_ready;

  // Stage s can load when some stage at or above it is empty (beats compact
  // into the hole) or the output is draining this cycle. This is the
  // unrolled form of "empty, or the next stage loads", with no comb chain.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_load
    assign load[gi] = ~(&v_q[DEPTH-1:gi]) | i_ready;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      if (load[0]) begin
        v_q[0]    <= i_valid;
        data_q[0] <= cap_data;
      end
      for (int s = 1; s < DEPTH; s++) begin
        if (load[s]) begin
          v_q[s] <= v_q[s-1];
          // A bubble moves up as v=0 only; the stale word stays put.
          if (v_q[s-1]) begin
            data_q[s] <= data_q[s-1];
          end
        end
      end
    end
  end

`ifdef NESTED_INTERFACE_PIPE_PARITY_EN
  // Parity is computed once at capture and travels with the word, so it is
  // registered exactly in step with o_data.
  logic [N_CH-1:0] cap_par;
  logic [N_CH-1:0] par_q [DEPTH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_par
    assign cap_par[gi] = ^cap_data[gi*WIDTH +: WIDTH];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        par_q[s] <= '0;
      end
    end else begin
      if (load[0]) begin
        par_q[0] <= cap_par;
      end
      for (int s = 1; s < DEPTH; s++) begin
        if (load[s] && v_q[s-1]) begin
          par_q[s] <= par_q[s-1];
        end
      end
    end
  end

  assign o_parity = par_q[DEPTH-1];
`endif

  always_comb begin
    count_d = count_q;
    if (xfer) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: tb/tb_nested_interface_pipe.sv
module tb_nested_interface_pipe;

  localparam int WIDTH = 8;
  localparam int N_CH  = 2;
  localparam int DEPTH = 2;
  localparam int DW    = WIDTH * N_CH;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          valid = 1'b0;
  logic          ready = 1'b1;
  logic [DW-1:0] data  = '0;
  logic [N_CH-1:0] inv = '0;

  logic          ordy, ovld;
  logic [DW-1:0] odata;
  logic [15:0]   ocnt;
  logic          ordy4, ovld4;
  logic [DW-1:0] odata4;
  logic [3:0]    ocnt4;
`ifdef NESTED_INTERFACE_PIPE_PARITY_EN
  logic [N_CH-1:0] opar, opar4;
`endif

  always #5 clk = ~clk;

  nested_interface_pipe #(.WIDTH(WIDTH), .N_CH(N_CH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (ordy),
    .i_data  (data),
    .i_inv   (inv),
    .o_valid (ovld),
    .i_ready (ready),
    .o_data  (odata),
`ifdef NESTED_INTERFACE_PIPE_PARITY_EN
    .o_parity(opar),
`endif
    .o_count (ocnt)
  );

  // Same stimulus, narrow counter to exercise wrap-around.
  nested_interface_pipe #(.WIDTH(WIDTH), .N_CH(N_CH), .DEPTH(DEPTH), .CNT_W(4)) dut_c4 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (ordy4),
    .i_data  (data),
    .i_inv   (inv),
    .o_valid (ovld4),
    .i_ready (ready),
    .o_data  (odata4),
`ifdef NESTED_INTERFACE_PIPE_PARITY_EN
    .o_parity(opar4),
`endif
    .o_count (ocnt4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit go      = 1'b0;

  typedef struct {
    logic [DW-1:0] word;
    int            acc;
  } beat_t;

  beat_t exp_q[$];
  int    cyc    = 0;
  int    mcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] d, input logic [N_CH-1:0] iv);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      logic [WIDTH-1:0] lane;
      lane = d[k*WIDTH +: WIDTH];
      r[k*WIDTH +: WIDTH] = iv[k] ? ~lane : lane;
    end
    return r;
  endfunction

  function automatic logic [N_CH-1:0] model_par(input logic [DW-1:0] w);
    logic [N_CH-1:0] p;
    for (int k = 0; k < N_CH; k++) begin
      logic [WIDTH-1:0] lane;
      lane = w[k*WIDTH +: WIDTH];
      p[k] = ^lane;
    end
    return p;
  endfunction

  // Reference model: a FIFO of accepted beats. A beat accepted in cycle c is
  // visible at the output from cycle c+DEPTH on, provided it is at the head.
  // Occupancy below DEPTH or a draining output means a beat can be accepted.
  initial begin
    bit    ev, er;
    beat_t b;
    wait (go);
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_o_valid", 32'(ovld), 32'd0);
        check("rst_o_data", 32'(odata), 32'd0);
        check("rst_o_ready", 32'(ordy), 32'd1);
        check("rst_o_count", 32'(ocnt), 32'd0);
        check("rst_o_count_c4", 32'(ocnt4), 32'd0);
        exp_q.delete();
        mcount = 0;
      end else begin
        ev = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + DEPTH);
        er = (exp_q.size() < DEPTH) || ready;
        check("o_ready", 32'(ordy), 32'(er));
        check("o_ready_c4", 32'(ordy4), 32'(er));
        check("o_valid", 32'(ovld), 32'(ev));
        check("o_valid_c4", 32'(ovld4), 32'(ev));
        if (ev) begin
          check("o_data", 32'(odata), 32'(exp_q[0].word));
          check("o_data_c4", 32'(odata4), 32'(exp_q[0].word));
`ifdef NESTED_INTERFACE_PIPE_PARITY_EN
          check("o_parity", 32'(opar), 32'(model_par(exp_q[0].word)));
          check("o_parity_c4", 32'(opar4), 32'(model_par(exp_q[0].word)));
`endif
        end
        check("o_count", 32'(ocnt), 32'(mcount % 65536));
        check("o_count_c4", 32'(ocnt4), 32'(mcount % 16));
        if (ev && ready) begin
          b = exp_q.pop_front();
          mcount++;
          $display("[TB] cycle %0d out beat %h count %0d", cyc, b.word, mcount);
        end
        if (valid && er) begin
          b.word = model_word(data, inv);
          b.acc  = cyc;
          exp_q.push_back(b);
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [N_CH-1:0] iv, input logic r);
    valid = v;
    data  = d;
    inv   = iv;
    ready = r;
  endtask

  // Called just after a rising edge: asserts reset mid-cycle, checks the
  // asynchronous effect, then releases it after the next edge.
  task automatic reset_pulse();
    #1;
    rst   = 1'b1;
    valid = 1'b0;
    #1;
    check("async_rst_o_valid", 32'(ovld), 32'd0);
    check("async_rst_o_data", 32'(odata), 32'd0);
    check("async_rst_o_count", 32'(ocnt), 32'd0);
    check("async_rst_o_ready", 32'(ordy), 32'd1);
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    valid = 1'b0;
    ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] stall_data;
    logic [39:0]   pv;
    logic [39:0]   pr;
    pv = 40'hF7_BD6F_E3D9;
    pr = 40'h3C_A5F0_9966;

    step();
    go = 1'b1;
    reset_pulse();

    // Single beat with lane 1 inverted.
    drive(1'b1, 16'hA50F, 2'b10, 1'b1);
    step();
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    step();
    @(negedge clk);
    check("single_valid", 32'(ovld), 32'd1);
    check("single_data", 32'(odata), 32'h5A0F);
    step();
    @(negedge clk);
    check("single_count", 32'(ocnt), 32'd1);

    // Streaming 100 beats.
    step();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'(16'h1000 + i), 2'b00, 1'b1);
      step();
    end
    wait_drain();
    check("stream_count", 32'(ocnt), 32'd101);

    // Backpressure: 2 beats fill the pipe, 3rd is held off.
    step();
    drive(1'b1, 16'h00B1, 2'b00, 1'b0);
    step();
    drive(1'b1, 16'h00B2, 2'b00, 1'b0);
    step();
    drive(1'b1, 16'h00B3, 2'b00, 1'b0);
    @(negedge clk);
    check("bp_ready_full", 32'(ordy), 32'd0);
    check("bp_head_data", 32'(odata), 32'h00B1);
    stall_data = odata;
    step();
    @(negedge clk);
    check("bp_data_stable", 32'(odata), 32'(stall_data));
    check("bp_still_full", 32'(ordy), 32'd0);
    step();
    ready = 1'b1;
    #1;
    check("bp_ready_rise", 32'(ordy), 32'd1);
    step();
    valid = 1'b0;
    wait_drain();
    check("bp_count", 32'(ocnt), 32'd104);

    // Mixed valid/ready patterns with varied inversion.
    step();
    for (int i = 0; i < 40; i++) begin
      drive(pv[i], 16'(16'h7700 + i * 5), 2'(i), pr[i]);
      step();
    end
    wait_drain();

    // Mid-stream reset with two beats in flight.
    step();
    drive(1'b1, 16'hC1C1, 2'b00, 1'b1);
    step();
    drive(1'b1, 16'hC2C2, 2'b00, 1'b1);
    step();
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    reset_pulse();
    check("mr_count", 32'(ocnt), 32'd0);
    drive(1'b1, 16'hD00D, 2'b01, 1'b1);
    step();
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    @(negedge clk);
    check("mr_lat_early", 32'(ovld), 32'd0);
    step();
    @(negedge clk);
    check("mr_lat_valid", 32'(ovld), 32'd1);
    check("mr_lat_data", 32'(odata), 32'hD0F2);

    // Counter wrap: 16 more transfers gives 17 total.
    step();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'(16'hE000 + i), 2'b00, 1'b1);
      step();
    end
    wait_drain();
    check("wrap_count_c4", 32'(ocnt4), 32'd1);
    check("wrap_count_c16", 32'(ocnt), 32'd17);

`ifdef NESTED_INTERFACE_PIPE_PARITY_EN
    step();
    drive(1'b1, 16'h0307, 2'b00, 1'b1);
    step();
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    step();
    @(negedge clk);
    check("par_valid", 32'(ovld), 32'd1);
    check("par_bits", 32'(opar), 32'h1);
    wait_drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
